// File: rtl/rsp_s1_prep_acc.sv
// rsp_s1_prep_acc
//   Accumulates N_TAPS signed products into one group sum. The sum is
//   rounded half-up, right-shifted by SHIFT and saturated to OUT_width, then
//   presented on a single-entry valid/ready output register.
//
// Ports
//   CLK       in   clock, rising edge
//   RST       in   synchronous active-high reset
//   PRODUCT   in   signed product from the upstream multiplier
//   IN_VLD    in   PRODUCT is valid this cycle (upstream cannot stall)
//   SYNC      in   group restart; the current cycle becomes tap 0
//   DOUT      out  rounded, saturated group sum
//   DOUT_VLD  out  DOUT holds an unconsumed result
//   OUT_RDY   in   downstream accepts DOUT when DOUT_VLD && OUT_RDY
//   DOUT_SAT  out  DOUT was clamped; qualified by DOUT_VLD
//   DROP      out  one-cycle pulse: a completed result was discarded
module rsp_s1_prep_acc #(
  parameter int P_width   = 15,
  parameter int N_TAPS    = 8,
  parameter int ACC_width = 23,
  parameter int SHIFT     = 4,
  parameter int OUT_width = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [P_width-1:0]   PRODUCT,
  input  logic                 IN_VLD,
  input  logic                 SYNC,
  output logic [OUT_width-1:0] DOUT,
  output logic                 DOUT_VLD,
  input  logic                 OUT_RDY,
  output logic                 DOUT_SAT,
  output logic                 DROP
);

  localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

  // Rounding and clamp limits live at ACC_width+1 bits so the half-LSB
  // addition cannot wrap a sum sitting at the accumulator's extremes.
  localparam logic signed [ACC_width:0] HALF = (ACC_width + 1)'(1) << (SHIFT - 1);
  localparam logic signed [ACC_width:0] MAXV = (ACC_width + 1)'((1 << (OUT_width - 1)) - 1);
  localparam logic signed [ACC_width:0] MINV = ~MAXV;

  logic [CNT_W-1:0]            r_cnt;
  logic signed [ACC_width-1:0] r_acc;
  logic [OUT_width-1:0]        r_dout;
  logic                        r_sat;
  logic                        r_vld;
  logic                        r_drop;

  logic signed [ACC_width-1:0] w_ext;
  logic signed [ACC_width-1:0] w_sum;
  logic signed [ACC_width:0]   w_sum_x;
  logic signed [ACC_width:0]   w_rnd;
  logic                        w_complete;
  logic                        w_hi;
  logic                        w_lo;
  logic [OUT_width-1:0]        w_dout;
  logic                        w_sat;

  always_comb begin
    w_ext      = {{(ACC_width - P_width){PRODUCT[P_width-1]}}, PRODUCT};
    w_sum      = r_acc + w_ext;
    // Completion is judged on the tap counter alone, so a SYNC arriving on
    // the last tap still delivers that group's result.
    w_complete = IN_VLD && (r_cnt == LAST_TAP);
    w_sum_x    = {w_sum[ACC_width-1], w_sum};
    w_rnd      = (w_sum_x + HALF) >>> SHIFT;
    w_hi       = (w_rnd > MAXV);
    w_lo       = (w_rnd < MINV);
    w_sat      = w_hi || w_lo;
    if (w_hi) begin
      w_dout = MAXV[OUT_width-1:0];
    end else if (w_lo) begin
      w_dout = MINV[OUT_width-1:0];
    end else begin
      w_dout = w_rnd[OUT_width-1:0];
    end
  end

  // Tap counter and accumulator.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (SYNC) begin
      if (IN_VLD) begin
        r_acc <= w_ext;
        r_cnt <= CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end else if (IN_VLD) begin
      r_acc <= (r_cnt == '0) ? w_ext : w_sum;
      r_cnt <= w_complete ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Single-entry output register: a completing result is taken if the
  // register is empty or being drained this cycle, otherwise it is dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dout <= '0;
      r_sat  <= 1'b0;
      r_vld  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      if (w_complete && (!r_vld || OUT_RDY)) begin
        r_dout <= w_dout;
        r_sat  <= w_sat;
        r_vld  <= 1'b1;
      end else if (w_complete) begin
        r_drop <= 1'b1;
      end else if (r_vld && OUT_RDY) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign DOUT     = r_dout;
  assign DOUT_SAT = r_sat;
  assign DOUT_VLD = r_vld;
  assign DROP     = r_drop;

endmodule

// File: tb/tb_rsp_s1_prep_acc.sv
// Testbench for rsp_s1_prep_acc: directed scenarios followed by random
// traffic; a reference model predicts results into a scoreboard queue and a
// monitor checks them at each output handshake.
module tb_rsp_s1_prep_acc;

  localparam int NT   = 4;
  localparam int PW   = 15;
  localparam int AW   = 17;
  localparam int SH   = 2;
  localparam int OW   = 8;
  localparam int OMAX = 127;
  localparam int OMIN = -128;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [PW-1:0] PRODUCT = '0;
  logic          IN_VLD = 1'b0;
  logic          SYNC = 1'b0;
  logic [OW-1:0] DOUT;
  logic          DOUT_VLD;
  logic          OUT_RDY = 1'b1;
  logic          DOUT_SAT;
  logic          DROP;

  rsp_s1_prep_acc #(
    .P_width(PW), .N_TAPS(NT), .ACC_width(AW), .SHIFT(SH), .OUT_width(OW)
  ) dut (
    .CLK(CLK), .RST(RST), .PRODUCT(PRODUCT), .IN_VLD(IN_VLD), .SYNC(SYNC),
    .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .OUT_RDY(OUT_RDY),
    .DOUT_SAT(DOUT_SAT), .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  typedef struct { int d; bit s; } res_t;
  res_t scb[$];

  int errors = 0;
  int checks = 0;
  int exp_drops = 0;
  int drops_seen = 0;

  // reference model state: taps collected so far in the open group
  int  m_taps[$];
  bit  m_full = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Half-up rounding by floor division, then clamping.
  function automatic res_t expected(int sum);
    res_t r;
    int n, q;
    n = sum + (1 << (SH - 1));
    q = n / (1 << SH);
    if ((n % (1 << SH) != 0) && (n < 0)) q = q - 1;
    r.s = (q > OMAX) || (q < OMIN);
    r.d = (q > OMAX) ? OMAX : ((q < OMIN) ? OMIN : q);
    return r;
  endfunction

  task automatic model(input bit rst, input bit vld, input bit sync,
                       input int p, input bit rdy);
    int sum;
    bit comp;
    if (rst) begin
      m_taps.delete();
      m_full = 0;
      scb.delete();
      return;
    end
    comp = vld && (m_taps.size() == NT - 1);
    if (comp) begin
      sum = p;
      foreach (m_taps[i]) sum += m_taps[i];
      if (!m_full || rdy) begin
        scb.push_back(expected(sum));
        m_full = 1;
      end else begin
        exp_drops++;
      end
    end else if (m_full && rdy) begin
      m_full = 0;
    end
    if (sync) m_taps.delete();
    if (vld) begin
      if (comp && !sync) m_taps.delete();
      else m_taps.push_back(p);
    end
  endtask

  task automatic step(input bit rst, input bit vld, input bit sync,
                      input int p, input bit rdy);
    @(negedge CLK);
    RST = rst; IN_VLD = vld; SYNC = sync; PRODUCT = PW'(p); OUT_RDY = rdy;
    model(rst, vld, sync, p, rdy);
  endtask

  task automatic group(input int a, input int b, input int c, input int d,
                       input bit rdy);
    step(0, 1, 0, a, rdy);
    step(0, 1, 0, b, rdy);
    step(0, 1, 0, c, rdy);
    step(0, 1, 0, d, rdy);
  endtask

  // Monitor: inputs for the coming edge are already driven at negedge, so a
  // handshake is recognised here and the presented result checked.
  logic [OW-1:0] prev_dout;
  logic          prev_sat;
  bit            prev_hold = 0;

  always @(negedge CLK) begin
    res_t e;
    #2;
    if (prev_hold) begin
      chk("hold_vld",  int'(DOUT_VLD), 1);
      chk("hold_dout", int'($signed(DOUT)), int'($signed(prev_dout)));
      chk("hold_sat",  int'(DOUT_SAT), int'(prev_sat));
    end
    if (!RST && DOUT_VLD && OUT_RDY) begin
      if (scb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = scb.pop_front();
        chk("dout", int'($signed(DOUT)), e.d);
        chk("dout_sat", int'(DOUT_SAT), int'(e.s));
      end
    end
    if (DROP) drops_seen++;
    prev_hold = DOUT_VLD && !OUT_RDY && !RST;
    prev_dout = DOUT;
    prev_sat  = DOUT_SAT;
  end

  initial begin
    int p, mode;
    bit r, v, s, rd;

    step(1, 1, 1, 123, 1);
    step(1, 0, 0, 0, 1);
    #3;
    chk("rst_vld",  int'(DOUT_VLD), 0);
    chk("rst_dout", int'(DOUT), 0);
    chk("rst_sat",  int'(DOUT_SAT), 0);
    chk("rst_drop", int'(DROP), 0);

    // basic group and one-cycle latency
    step(0, 1, 0, 10, 1);
    step(0, 1, 0, 20, 1);
    step(0, 1, 0, 30, 1);
    step(0, 1, 0, 40, 1);
    #1 chk("lat_before", int'(DOUT_VLD), 0);
    @(posedge CLK); #1;
    chk("lat_vld", int'(DOUT_VLD), 1);
    chk("lat_dout", int'($signed(DOUT)), 25);

    // idle gaps between taps
    step(0, 1, 0, -1, 1);
    step(0, 0, 0, 77, 1);
    step(0, 1, 0, -1, 1);
    step(0, 0, 0, 99, 1);
    step(0, 0, 0, 5, 1);
    step(0, 1, 0, -1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, -3, 1);
    step(0, 0, 0, 0, 1);

    // saturation both ways
    group(1000, 1000, 1000, 1000, 1);
    group(-1000, -1000, -1000, -1000, 1);
    step(0, 0, 0, 0, 1);

    // back-pressure: second result dropped, first kept
    group(25, 25, 25, 25, 0);
    group(50, 50, 50, 50, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    @(posedge CLK); #1;
    chk("vld_clear", int'(DOUT_VLD), 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    #3 chk("drop_count_bp", drops_seen, exp_drops);
    chk("drop_count_one", exp_drops, 1);

    // SYNC aborts a partial group
    step(0, 1, 0, 300, 1);
    step(0, 1, 0, 400, 1);
    step(0, 1, 1, 8, 1);
    step(0, 1, 0, 4, 1);
    step(0, 1, 0, 4, 1);
    step(0, 1, 0, 4, 1);
    step(0, 0, 0, 0, 1);

    // reset mid-group
    step(0, 1, 0, 500, 1);
    step(0, 1, 0, 500, 1);
    step(0, 1, 0, 500, 1);
    step(1, 1, 0, 500, 1);
    #3 chk("rst_mid_vld", int'(DOUT_VLD), 0);
    group(8, 8, 8, 8, 1);
    step(0, 0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      mode = int'($urandom_range(0, 2));
      if (mode == 0)      p = int'($urandom_range(0, 32767)) - 16384;
      else if (mode == 1) p = int'($urandom_range(0, 400)) - 200;
      else                p = int'($urandom_range(0, 8)) - 4;
      r  = ($urandom_range(0, 99) < 1);
      v  = ($urandom_range(0, 99) < 70);
      s  = ($urandom_range(0, 99) < 4);
      rd = ($urandom_range(0, 99) < 65);
      step(r, v, s, p, rd);
    end

    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    #3;
    chk("scb_empty", scb.size(), 0);
    chk("final_vld", int'(DOUT_VLD), 0);
    chk("drop_total", drops_seen, exp_drops);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
